// File: rtl/mac_overlay_scheduler_pkg.sv
// Shared types and widths for the MAC overlay scheduler and its term pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_overlay_scheduler_pkg;

    localparam int LEN_W = 16;
    localparam int A_W   = 27;
    localparam int B_W   = 18;
    localparam int S_W   = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mac_term_pipe.sv
// Term pipeline: issue regs, flag/bias shift registers aligned to the overlay, X/CIN select, result capture.
// Latency: issue edge t -> overlay input regs t+1 -> product t+2 -> S_reg t+3 -> res_valid at t+4.
// Backpressure: none; every issued term advances one stage per clock.
module mac_term_pipe #(
    parameter int A_W = mac_overlay_scheduler_pkg::A_W,
    parameter int B_W = mac_overlay_scheduler_pkg::B_W,
    parameter int S_W = mac_overlay_scheduler_pkg::S_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           issue,
    input  logic           term_first,
    input  logic           term_last,
    input  logic [A_W-1:0] term_a,
    input  logic [B_W-1:0] term_b,
    input  logic [S_W-1:0] bias,
    input  logic           cin,
    input  logic           ov_clr,
    input  logic [S_W-1:0] ov_s,
    input  logic           ov_cout,
    output logic [A_W-1:0] ov_a,
    output logic [B_W-1:0] ov_b,
    output logic [S_W-1:0] ov_x,
    output logic           ov_cin,
    output logic           res_valid,
    output logic [S_W-1:0] res_data,
    output logic           res_cout
);

    logic           first_s0, last_s0, cin_s0;
    logic           first_p,  last_p,  cin_p;
    logic           first_s1, last_s1, cin_s1;
    logic           last_s2;
    logic [S_W-1:0] bias_s0, bias_p, bias_s1;

    // Bias/cin travel with the first term so a back-to-back command cannot
    // overwrite them before the previous vector's first add consumes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_a      <= '0;
            ov_b      <= '0;
            first_s0  <= 1'b0;
            last_s0   <= 1'b0;
            cin_s0    <= 1'b0;
            bias_s0   <= '0;
            first_p   <= 1'b0;
            last_p    <= 1'b0;
            cin_p     <= 1'b0;
            bias_p    <= '0;
            first_s1  <= 1'b0;
            last_s1   <= 1'b0;
            cin_s1    <= 1'b0;
            bias_s1   <= '0;
            last_s2   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
        end else begin
            ov_a     <= term_a;
            ov_b     <= term_b;
            first_s0 <= issue & term_first;
            last_s0  <= issue & term_last;
            if (issue && term_first) begin
                bias_s0 <= bias;
                cin_s0  <= cin;
            end
            first_p <= first_s0;
            last_p  <= last_s0;
            if (first_s0) begin
                bias_p <= bias_s0;
                cin_p  <= cin_s0;
            end
            first_s1 <= first_p;
            last_s1  <= last_p;
            if (first_p) begin
                bias_s1 <= bias_p;
                cin_s1  <= cin_p;
            end
            last_s2   <= last_s1;
            res_valid <= last_s2;
            if (last_s2) begin
                res_data <= ov_s;
                res_cout <= ov_cout;
            end
        end
    end

    // While the overlay is held in reset its S_reg is not trusted, so feed back zero.
    assign ov_x   = first_s1 ? bias_s1 : (ov_clr ? '0 : ov_s);
    assign ov_cin = first_s1 & cin_s1;

endmodule

// File: rtl/mac_overlay_scheduler.sv
// Streams (a,b) pairs into a 27x18 MAC overlay, accumulating via X feedback; one 48-bit sum per command.
// Latency: last operand handshake at edge t -> res_valid high after edge t+4.
// Backpressure: cmd_ready/op_ready valid-ready on inputs; results are strobed with no backpressure.
module mac_overlay_scheduler #(
    parameter int LEN_W = mac_overlay_scheduler_pkg::LEN_W,
    parameter int A_W   = mac_overlay_scheduler_pkg::A_W,
    parameter int B_W   = mac_overlay_scheduler_pkg::B_W,
    parameter int S_W   = mac_overlay_scheduler_pkg::S_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [S_W-1:0]   cmd_bias,
    input  logic             cmd_cin,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [A_W-1:0]   op_a,
    input  logic [B_W-1:0]   op_b,
    output logic             ov_rst,
    output logic [A_W-1:0]   ov_a,
    output logic [B_W-1:0]   ov_b,
    output logic [S_W-1:0]   ov_x,
    output logic             ov_cin,
    input  logic [S_W-1:0]   ov_s,
    input  logic             ov_cout,
    output logic             res_valid,
    output logic [S_W-1:0]   res_data,
    output logic             res_cout
);

    import mac_overlay_scheduler_pkg::*;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic             first_q, zero_q, cin_q;
    logic [S_W-1:0]   bias_q;
    logic             rel_q1, rel_q2;
    logic             cmd_hs, op_hs, issue, term_last;
    logic [A_W-1:0]   term_a;
    logic [B_W-1:0]   term_b;

    // Overlay reset releases two edges after the block leaves reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_q1 <= 1'b0;
            rel_q2 <= 1'b0;
        end else begin
            rel_q1 <= 1'b1;
            rel_q2 <= rel_q1;
        end
    end

    assign ov_rst = ~rel_q2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = RUN;
            RUN:     if (issue && term_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        case (state)
            IDLE:    cmd_ready = ~ov_rst;
            RUN:     op_ready  = ~zero_q;
            default: ;
        endcase
    end

    assign cmd_hs    = cmd_valid & cmd_ready;
    assign op_hs     = op_valid & op_ready;
    // A zero-length command issues a single zero-product term so bias+cin still flows through.
    assign issue     = op_hs | ((state == RUN) & zero_q);
    assign term_last = (cnt == LEN_W'(1));
    assign term_a    = op_hs ? op_a : '0;
    assign term_b    = op_hs ? op_b : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            first_q <= 1'b0;
            zero_q  <= 1'b0;
            bias_q  <= '0;
            cin_q   <= 1'b0;
        end else if (cmd_hs) begin
            cnt     <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            first_q <= 1'b1;
            zero_q  <= (cmd_len == '0);
            bias_q  <= cmd_bias;
            cin_q   <= cmd_cin;
        end else if (issue) begin
            cnt     <= cnt - LEN_W'(1);
            first_q <= 1'b0;
        end
    end

    mac_term_pipe #(
        .A_W (A_W),
        .B_W (B_W),
        .S_W (S_W)
    ) u_term_pipe (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .term_first (first_q),
        .term_last  (term_last),
        .term_a     (term_a),
        .term_b     (term_b),
        .bias       (bias_q),
        .cin        (cin_q),
        .ov_clr     (ov_rst),
        .ov_s       (ov_s),
        .ov_cout    (ov_cout),
        .ov_a       (ov_a),
        .ov_b       (ov_b),
        .ov_x       (ov_x),
        .ov_cin     (ov_cin),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_cout   (res_cout)
    );

endmodule

// File: tb/tb_mac_overlay_scheduler.sv
// Bench: directed cases plus randomized vectors against a dot-product reference model.
module tb_mac_overlay_scheduler;

    localparam int LEN_W = 16;
    localparam int A_W   = 27;
    localparam int B_W   = 18;
    localparam int S_W   = 48;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [S_W-1:0]   cmd_bias = '0;
    logic             cmd_cin = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [A_W-1:0]   op_a = '0;
    logic [B_W-1:0]   op_b = '0;
    logic             ov_rst;
    logic [A_W-1:0]   ov_a;
    logic [B_W-1:0]   ov_b;
    logic [S_W-1:0]   ov_x;
    logic             ov_cin;
    logic [S_W-1:0]   ov_s;
    logic             ov_cout;
    logic             res_valid;
    logic [S_W-1:0]   res_data;
    logic             res_cout;

    always #5 clk = ~clk;

    mac_overlay_scheduler #(
        .LEN_W (LEN_W), .A_W (A_W), .B_W (B_W), .S_W (S_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_bias  (cmd_bias),
        .cmd_cin   (cmd_cin),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .ov_rst    (ov_rst),
        .ov_a      (ov_a),
        .ov_b      (ov_b),
        .ov_x      (ov_x),
        .ov_cin    (ov_cin),
        .ov_s      (ov_s),
        .ov_cout   (ov_cout),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_cout  (res_cout)
    );

    // Overlay model: input regs, product reg, then S_reg = P + X + CIN.
    logic [A_W-1:0] m_a = '0;
    logic [B_W-1:0] m_b = '0;
    logic [S_W-1:0] m_p = '0;
    logic [S_W-1:0] m_s = '0;
    logic           m_cout = 1'b0;
    logic [S_W:0]   m_sum;

    assign m_sum   = {1'b0, m_p} + {1'b0, ov_x} + {{S_W{1'b0}}, ov_cin};
    assign ov_s    = m_s;
    assign ov_cout = m_cout;

    always @(posedge clk) begin
        if (ov_rst) begin
            m_a <= '0; m_b <= '0; m_p <= '0; m_s <= '0; m_cout <= 1'b0;
        end else begin
            m_a    <= ov_a;
            m_b    <= ov_b;
            m_p    <= S_W'(longint'($signed(m_a)) * longint'($signed(m_b)));
            m_s    <= m_sum[S_W-1:0];
            m_cout <= m_sum[S_W];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit op_rdy_seen = 1'b0;

    logic [S_W-1:0] got_data[$];
    logic           got_cout[$];
    int             got_cyc[$];
    logic [S_W-1:0] exp_data[$];
    logic           exp_cout[$];
    int             exp_cyc[$];
    logic [S_W-1:0] saved[$];
    logic [A_W-1:0] va[$];
    logic [B_W-1:0] vb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid) begin
            got_data.push_back(res_data);
            got_cout.push_back(res_cout);
            got_cyc.push_back(cyc);
        end
        if (op_ready) op_rdy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Drives one command and its operand pairs from va/vb; the reference sum
    // is the plain dot product bias + cin + sum(a*b) mod 2^48, with cout taken
    // from the carry of the final three-input add.
    task automatic run_vec(input int len, input logic [S_W-1:0] bias, input bit cin,
                           input int gap, input bit gap_rand);
        logic [S_W:0]   tot;
        logic [S_W-1:0] acc;
        logic [S_W-1:0] p;
        int n;
        int hs;
        int g;
        acc = bias;
        tot = {1'b0, bias} + {{S_W{1'b0}}, cin};
        cmd_valid = 1'b1; cmd_len = LEN_W'(len); cmd_bias = bias; cmd_cin = cin;
        n = 0;
        while (!cmd_ready && n < 64) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            timeout("cmd_handshake");
            return;
        end
        hs = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            g = gap_rand ? int'($urandom_range(0, gap)) : gap;
            repeat (g) @(negedge clk);
            op_valid = 1'b1; op_a = va[i]; op_b = vb[i];
            n = 0;
            while (!op_ready && n < 64) begin @(negedge clk); n++; end
            if (!op_ready) begin
                op_valid = 1'b0;
                timeout("op_handshake");
                return;
            end
            hs = cyc + 1;
            @(negedge clk);
            op_valid = 1'b0;
            p = S_W'(longint'($signed(va[i])) * longint'($signed(vb[i])));
            if (i == 0) tot = {1'b0, p} + {1'b0, bias} + {{S_W{1'b0}}, cin};
            else        tot = {1'b0, p} + {1'b0, acc};
            acc = tot[S_W-1:0];
        end
        if (len == 0) hs = hs + 1;
        exp_data.push_back(tot[S_W-1:0]);
        exp_cout.push_back(tot[S_W]);
        exp_cyc.push_back(hs + 4);
    endtask

    task automatic check_results(input string tag);
        int k;
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        k = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < k; i++) begin
            chk({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
            chk({tag, "_cout"}, 64'(got_cout[i]), 64'(exp_cout[i]));
            chk({tag, "_latency"}, 64'(got_cyc[i]), 64'(exp_cyc[i]));
        end
        saved = got_data;
        got_data.delete(); got_cout.delete(); got_cyc.delete();
        exp_data.delete(); exp_cout.delete(); exp_cyc.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_iter;
        int len;
        repeat (3) @(negedge clk);
        chk("rst_ov_a", 64'(ov_a), 64'h0);
        chk("rst_ov_b", 64'(ov_b), 64'h0);
        chk("rst_ov_x", 64'(ov_x), 64'h0);
        chk("rst_ov_cin", 64'(ov_cin), 64'h0);
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_res_data", 64'(res_data), 64'h0);
        chk("rst_res_cout", 64'(res_cout), 64'h0);
        chk("rst_op_ready", 64'(op_ready), 64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("rst_ov_rst", 64'(ov_rst), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("rel1_ov_rst", 64'(ov_rst), 64'h1);
        chk("rel1_cmd_ready", 64'(cmd_ready), 64'h0);
        @(negedge clk);
        chk("rel2_ov_rst", 64'(ov_rst), 64'h0);
        chk("rel2_cmd_ready", 64'(cmd_ready), 64'h1);

        // Case 1: single term
        va = '{A_W'(3)}; vb = '{B_W'(5)};
        run_vec(1, '0, 1'b0, 0, 1'b0);
        check_results("case1");
        chk("case1_value", 64'(saved[0]), 64'd15);

        // Case 2: mixed signs
        va = '{A_W'(2), A_W'(-4), A_W'(7)}; vb = '{B_W'(3), B_W'(5), B_W'(-1)};
        run_vec(3, '0, 1'b0, 0, 1'b0);
        check_results("case2");
        chk("case2_value", 64'(saved[0]), 64'h0000_FFFF_FFFF_FFEB);

        // Case 3: same vector, two idle cycles before each pair
        run_vec(3, '0, 1'b0, 2, 1'b0);
        check_results("case3");
        chk("case3_value", 64'(saved[0]), 64'h0000_FFFF_FFFF_FFEB);

        // Case 4: back-to-back commands
        va = '{A_W'(1), A_W'(2)}; vb = '{B_W'(1), B_W'(2)};
        run_vec(2, 48'd100, 1'b0, 0, 1'b0);
        va = '{A_W'(10)}; vb = '{B_W'(10)};
        run_vec(1, '0, 1'b0, 0, 1'b0);
        check_results("case4");
        chk("case4_first", 64'(saved[0]), 64'd105);
        chk("case4_second", 64'(saved[1]), 64'd100);

        // Case 5: zero length
        op_rdy_seen = 1'b0;
        run_vec(0, 48'h0000_0000_1234, 1'b1, 0, 1'b0);
        check_results("case5");
        chk("case5_value", 64'(saved[0]), 64'h1235);
        chk("case5_op_ready_seen", 64'(op_rdy_seen), 64'h0);

        // Case 6: reset while term 2 of a 4-term vector is offered
        cmd_valid = 1'b1; cmd_len = LEN_W'(4); cmd_bias = '0; cmd_cin = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = A_W'(1); op_b = B_W'(1);
        @(negedge clk);
        op_a = A_W'(2); op_b = B_W'(2);
        reset = 1'b0;
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("case6_in_rst_ov_rst", 64'(ov_rst), 64'h1);
        chk("case6_in_rst_cmd_ready", 64'(cmd_ready), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("case6_rel1_ov_rst", 64'(ov_rst), 64'h1);
        @(negedge clk);
        chk("case6_rel2_ov_rst", 64'(ov_rst), 64'h0);
        repeat (6) @(negedge clk);
        chk("case6_no_result", 64'(got_data.size()), 64'h0);
        va = '{A_W'(6)}; vb = '{B_W'(7)};
        run_vec(1, '0, 1'b0, 0, 1'b0);
        check_results("case6");
        chk("case6_value", 64'(saved[0]), 64'd42);

        // Randomized vectors, mixing back-to-back issue and random gaps
        n_iter = 30;
        for (int it = 0; it < n_iter; it++) begin
            len = int'($urandom_range(0, 6));
            va.delete(); vb.delete();
            for (int i = 0; i < len; i++) begin
                va.push_back(A_W'($urandom));
                vb.push_back(B_W'($urandom));
            end
            run_vec(len, S_W'({$urandom, $urandom}), 1'($urandom), 2, 1'($urandom));
            if (it % 5 == 4) check_results("rand");
        end
        check_results("rand_tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
